// File: rtl/scanline_dma_fetch_if.sv
// Framebuffer bus between the scanline DMA and the CPU16/RAM side.
// The DMA raises hold and drives ram_addr. The CPU side answers with busy,
// and the RAM returns ram_data combinationally for the current ram_addr.
interface scanline_dma_fetch_if;
  logic        hold;
  logic        busy;
  logic [14:0] ram_addr;
  logic [15:0] ram_data;

  modport master (
    output hold,
    output ram_addr,
    input  busy,
    input  ram_data
  );

  modport slave (
    input  hold,
    input  ram_addr,
    output busy,
    output ram_data
  );
endinterface

// File: rtl/scanline_dma_fetch.sv
// Scanline DMA fetch: during horizontal blanking, copies the next framebuffer row
// (32 x 16-bit words) into the back bank of a double-buffered line store.
// During the active line, it serializes the front bank as 2-bit pixels through a
// 4-entry palette onto a registered rgb output.
module scanline_dma_fetch #(
  parameter logic [1:0] FB_BASE     = 2'b10,
  parameter int         H_ACTIVE    = 256,
  parameter int         V_ACTIVE    = 240,
  parameter int         V_TOTAL     = 262,
  parameter int         FETCH_START = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [8:0]                  hpos,
  input  logic [8:0]                  vpos,
  scanline_dma_fetch_if.master        mem_bus,
  input  logic                        pal_we,
  input  logic [1:0]                  pal_index,
  input  logic [3:0]                  pal_data,
  output logic [3:0]                  rgb,
  output logic                        underrun
);

  // Positions expressed at the width of the sync counters.
  localparam logic [8:0] H_ACT_L      = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT_L      = 9'(V_ACTIVE);
  localparam logic [8:0] V_FETCH_LAST = 9'(V_ACTIVE - 1);
  localparam logic [8:0] V_LAST       = 9'(V_TOTAL - 1);
  localparam logic [8:0] FETCH_H      = 9'(FETCH_START);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        hold_q, hold_d;
  logic [7:0]  tline_q, tline_d;
  logic [4:0]  widx_q, widx_d;
  logic        front_sel_q, front_sel_d;
  logic        valid_q, valid_d;
  logic        underrun_q, underrun_d;
  logic [3:0]  rgb_q, rgb_d;
  logic [3:0]  pal_q [4];
  logic [3:0]  pal_d [4];

  // Two banks of 32 words, addressed as {bank, word}.
  logic [15:0] line_mem [64];
  logic        line_we;
  logic        back_sel;

  logic        has_target;
  logic [7:0]  target_line;
  logic        line_start;
  logic        swap_now;
  logic        disp_sel;
  logic        disp_valid;
  logic [15:0] pix_word;
  logic [1:0]  pix;

  assign line_start = (hpos == 9'd0);
  assign back_sel   = ~front_sel_q;
  assign swap_now   = (state_q == S_DONE) && line_start;

  // Pick the row to prefetch: the next visible line, or line 0 from the last line of the frame.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    has_target  = 1'b0;
    target_line = 8'd0;
    if (vpos < V_FETCH_LAST) begin
      has_target  = 1'b1;
      target_line = vpos[7:0] + 8'd1;
    end else if (vpos == V_LAST) begin
      has_target  = 1'b1;
      target_line = 8'd0;
    end
  end

  // Fetch FSM: request the bus, copy 32 words on granted cycles, swap banks at line start.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    tline_d     = tline_q;
    widx_d      = widx_q;
    front_sel_d = front_sel_q;
    valid_d     = valid_q;
    underrun_d  = underrun_q;
    line_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hpos == FETCH_H && has_target) begin
          state_d = S_REQ;
          hold_d  = 1'b1;
          tline_d = target_line;
          widx_d  = 5'd0;
        end
      end
      S_REQ: begin
        if (line_start) begin
          // Grant never came before the line began: give up and keep the old front bank.
          state_d    = S_IDLE;
          hold_d     = 1'b0;
          underrun_d = 1'b1;
        end else if (mem_bus.busy) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (line_start) begin
          // Partial row in the back bank is simply discarded.
          state_d    = S_IDLE;
          hold_d     = 1'b0;
          underrun_d = 1'b1;
        end else if (mem_bus.busy) begin
          line_we = 1'b1;
          widx_d  = widx_q + 5'd1;
          if (widx_q == 5'd31) begin
            hold_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (line_start) begin
          state_d     = S_IDLE;
          front_sel_d = ~front_sel_q;
          valid_d     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Palette update; the pixel path reads pal_q, so a same-cycle write is seen one cycle later.
  always_comb begin
    pal_d = pal_q;
    if (pal_we) pal_d[pal_index] = pal_data;
  end

  // On the swap cycle, show the freshly fetched bank so hpos 0 already belongs to the new row.
  always_comb begin
    disp_sel   = front_sel_q;
    disp_valid = valid_q;
    if (swap_now) begin
      disp_sel   = back_sel;
      disp_valid = 1'b1;
    end
  end

  // Pixel serializer: the leftmost pixel of a word is its least significant bit pair.
  always_comb begin
    rgb_d    = 4'h0;
    pix_word = line_mem[{disp_sel, hpos[7:3]}];
    pix      = pix_word[{hpos[2:0], 1'b0} +: 2];
    if (hpos < H_ACT_L && vpos < V_ACT_L && disp_valid) rgb_d = pal_q[pix];
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      hold_q      <= 1'b0;
      tline_q     <= 8'd0;
      widx_q      <= 5'd0;
      front_sel_q <= 1'b0;
      valid_q     <= 1'b0;
      underrun_q  <= 1'b0;
      rgb_q       <= 4'h0;
      pal_q[0]    <= 4'h0;
      pal_q[1]    <= 4'h5;
      pal_q[2]    <= 4'hA;
      pal_q[3]    <= 4'hF;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      tline_q     <= tline_d;
      widx_q      <= widx_d;
      front_sel_q <= front_sel_d;
      valid_q     <= valid_d;
      underrun_q  <= underrun_d;
      rgb_q       <= rgb_d;
      pal_q       <= pal_d;
    end
  end

  // Line store write port, always into the bank that is not on display.
  always_ff @(posedge clk) begin
    // NOTE: the line store is deliberately not reset; valid_q gates its contents, and a reset-free array maps to RAM.
    if (line_we) line_mem[{back_sel, widx_q}] <= mem_bus.ram_data;
  end

  assign mem_bus.hold     = hold_q;
  assign mem_bus.ram_addr = (state_q == S_FETCH) ? {FB_BASE, tline_q, widx_q} : 15'd0;
  assign rgb              = rgb_q;
  assign underrun         = underrun_q;

endmodule
